// File: rtl/clock_set_ctrl_if.sv
// Strobe/display bundle between the button front end, clock_set_ctrl and the VGA renderer.
// Latency: none, wires only.
// Backpressure: none; strobes are one-cycle pulses and are always consumed.
// Ports: tick_1hz, btn_mode/next/up/down (strobes into the controller);
//        almacenamiento, posicion, cuadro, parpadeo (display drive out of it).
interface clock_set_ctrl_if;
    logic        tick_1hz;
    logic        btn_mode;
    logic        btn_next;
    logic        btn_up;
    logic        btn_down;
    logic [47:0] almacenamiento;
    logic [2:0]  posicion;
    logic        cuadro;
    logic        parpadeo;

    // Strobe source / display consumer side.
    modport master (
        output tick_1hz, btn_mode, btn_next, btn_up, btn_down,
        input  almacenamiento, posicion, cuadro, parpadeo
    );

    // Controller side.
    modport slave (
        input  tick_1hz, btn_mode, btn_next, btn_up, btn_down,
        output almacenamiento, posicion, cuadro, parpadeo
    );
endinterface

// File: rtl/clock_set_ctrl.sv
// BCD time/date keeper with RUN (1 Hz advance, calendar rollover) and EDIT (cursor, inc/dec, blink).
// Latency: every output is registered; a strobe takes effect 1 dclk cycle later.
// Backpressure: none; strobes are accepted every cycle, only the highest-priority one acts.
// Ports: dclk, clr_n (async active-low); bus = clock_set_ctrl_if.slave
//        (strobes in; almacenamiento {HH,MM,SS,DD,MO,YY}, posicion, cuadro, parpadeo out).
module clock_set_ctrl #(
    parameter int BLINK_DIV = 12500000
) (
    input  logic              dclk,
    input  logic              clr_n,
    clock_set_ctrl_if.slave   bus
);
    localparam int            CW       = $clog2(BLINK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_DIV - 1);

    typedef enum logic {S_RUN = 1'b0, S_EDIT = 1'b1} state_t;

    state_t        r_state, w_state_nxt;
    logic [7:0]    r_hh, r_mm, r_ss, r_dd, r_mo, r_yy;
    logic [7:0]    w_hh, w_mm, w_ss, w_dd, w_mo, w_yy;
    logic [2:0]    r_pos, w_pos;
    logic          r_cuadro;
    logic          r_blink, w_blink;
    logic [CW-1:0] r_cnt, w_cnt;
    logic [7:0]    w_dim;

    // BCD increment with wrap; ">=" also folds an out-of-range day back to lo.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lo,
                                           input logic [7:0] hi);
        if (v >= hi)             return lo;
        else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        else                     return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] lo,
                                           input logic [7:0] hi);
        if (v <= lo)             return hi;
        else if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
        else                     return {v[7:4], v[3:0] - 4'd1};
    endfunction

    // Divisible by 4 expressed on BCD digits: even tens need units 0/4/8, odd tens need 2/6.
    function automatic logic is_leap(input logic [7:0] yy);
        if (!yy[4]) return (yy[3:0] == 4'd0) || (yy[3:0] == 4'd4) || (yy[3:0] == 4'd8);
        else        return (yy[3:0] == 4'd2) || (yy[3:0] == 4'd6);
    endfunction

    function automatic logic [7:0] days_in_month(input logic [7:0] mo, input logic [7:0] yy);
        case (mo)
            8'h02:                      return is_leap(yy) ? 8'h29 : 8'h28;
            8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
            default:                    return 8'h31;
        endcase
    endfunction

    assign w_dim = days_in_month(r_mo, r_yy);

    // State register.
    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) r_state <= S_RUN;
        else        r_state <= w_state_nxt;
    end

    // Next state: only btn_mode moves between RUN and EDIT.
    always_comb begin
        w_state_nxt = r_state;
        if (bus.btn_mode) begin
            case (r_state)
                S_RUN:   w_state_nxt = S_EDIT;
                S_EDIT:  w_state_nxt = S_RUN;
                default: w_state_nxt = S_RUN;
            endcase
        end
    end

    // Output/datapath next values.
    always_comb begin
        w_hh    = r_hh;
        w_mm    = r_mm;
        w_ss    = r_ss;
        w_dd    = r_dd;
        w_mo    = r_mo;
        w_yy    = r_yy;
        w_pos   = r_pos;
        w_blink = r_blink;
        w_cnt   = r_cnt;
        case (r_state)
            S_RUN: begin
                // A tick is applied even when btn_mode arrives in the same cycle.
                if (bus.tick_1hz) begin
                    w_ss = bcd_inc(r_ss, 8'h00, 8'h59);
                    if (r_ss == 8'h59) begin
                        w_mm = bcd_inc(r_mm, 8'h00, 8'h59);
                        if (r_mm == 8'h59) begin
                            w_hh = bcd_inc(r_hh, 8'h00, 8'h23);
                            if (r_hh == 8'h23) begin
                                w_dd = bcd_inc(r_dd, 8'h01, w_dim);
                                if (r_dd >= w_dim) begin
                                    w_mo = bcd_inc(r_mo, 8'h01, 8'h12);
                                    if (r_mo == 8'h12) w_yy = bcd_inc(r_yy, 8'h00, 8'h99);
                                end
                            end
                        end
                    end
                end
                w_pos   = 3'd0;
                w_blink = 1'b1;
                w_cnt   = '0;
            end
            S_EDIT: begin
                if (bus.btn_mode) begin
                    w_pos   = 3'd0;
                    w_blink = 1'b1;
                    w_cnt   = '0;
                    // Leaving EDIT must not leave e.g. 31/02 behind.
                    if (r_dd > w_dim) w_dd = w_dim;
                end else if (bus.btn_next || bus.btn_up || bus.btn_down) begin
                    // Any user action restarts the blink with the field visible.
                    w_blink = 1'b1;
                    w_cnt   = '0;
                    if (bus.btn_next) begin
                        w_pos = (r_pos == 3'd5) ? 3'd0 : r_pos + 3'd1;
                    end else begin
                        case (r_pos)
                            3'd0: w_hh = bus.btn_up ? bcd_inc(r_hh, 8'h00, 8'h23)
                                                    : bcd_dec(r_hh, 8'h00, 8'h23);
                            3'd1: w_mm = bus.btn_up ? bcd_inc(r_mm, 8'h00, 8'h59)
                                                    : bcd_dec(r_mm, 8'h00, 8'h59);
                            3'd2: w_ss = bus.btn_up ? bcd_inc(r_ss, 8'h00, 8'h59)
                                                    : bcd_dec(r_ss, 8'h00, 8'h59);
                            3'd3: w_dd = bus.btn_up ? bcd_inc(r_dd, 8'h01, w_dim)
                                                    : bcd_dec(r_dd, 8'h01, w_dim);
                            3'd4: w_mo = bus.btn_up ? bcd_inc(r_mo, 8'h01, 8'h12)
                                                    : bcd_dec(r_mo, 8'h01, 8'h12);
                            3'd5: w_yy = bus.btn_up ? bcd_inc(r_yy, 8'h00, 8'h99)
                                                    : bcd_dec(r_yy, 8'h00, 8'h99);
                            default: ;
                        endcase
                    end
                end else if (r_cnt == CNT_LAST) begin
                    w_cnt   = '0;
                    w_blink = ~r_blink;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            r_hh     <= 8'h00;
            r_mm     <= 8'h00;
            r_ss     <= 8'h00;
            r_dd     <= 8'h01;
            r_mo     <= 8'h01;
            r_yy     <= 8'h00;
            r_pos    <= 3'd0;
            r_cuadro <= 1'b0;
            r_blink  <= 1'b1;
            r_cnt    <= '0;
        end else begin
            r_hh     <= w_hh;
            r_mm     <= w_mm;
            r_ss     <= w_ss;
            r_dd     <= w_dd;
            r_mo     <= w_mo;
            r_yy     <= w_yy;
            r_pos    <= w_pos;
            r_cuadro <= (w_state_nxt == S_EDIT);
            r_blink  <= w_blink;
            r_cnt    <= w_cnt;
        end
    end

    assign bus.almacenamiento = {r_hh, r_mm, r_ss, r_dd, r_mo, r_yy};
    assign bus.posicion       = r_pos;
    assign bus.cuadro         = r_cuadro;
    assign bus.parpadeo       = r_blink;
endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: directed steps plus random strobes against a calendar model.
// Latency: expects each strobe's effect one dclk after it is applied.
// Backpressure: none exercised; strobes are driven freely.
module tb_clock_set_ctrl;
    localparam int BD = 4;

    logic dclk = 1'b0;
    logic clr_n;
    always #5 dclk = ~dclk;

    clock_set_ctrl_if u_if ();

    clock_set_ctrl #(.BLINK_DIV(BD)) u_dut (
        .dclk  (dclk),
        .clr_n (clr_n),
        .bus   (u_if.slave)
    );

    int checks = 0;
    int errors = 0;

    // Model: plain integers, index 0=HH 1=MM 2=SS 3=DD 4=MO 5=YY.
    int m_f[6];
    int m_pos;
    bit m_edit;
    int m_n;   // idle EDIT cycles since the last blink restart

    function automatic int dim(input int mo, input int yy);
        if (mo == 2) return (yy % 4 == 0) ? 29 : 28;
        if (mo == 4 || mo == 6 || mo == 9 || mo == 11) return 30;
        return 31;
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    function automatic logic [47:0] exp_alm();
        return {to_bcd(m_f[0]), to_bcd(m_f[1]), to_bcd(m_f[2]),
                to_bcd(m_f[3]), to_bcd(m_f[4]), to_bcd(m_f[5])};
    endfunction

    function automatic bit exp_blink();
        return m_edit ? (((m_n / BD) % 2) == 0) : 1'b1;
    endfunction

    task automatic model_reset();
        m_f = '{0, 0, 0, 1, 1, 0};
        m_pos = 0; m_edit = 1'b0; m_n = 0;
    endtask

    task automatic model_adjust(input int p, input bit up);
        int lo, hi;
        case (p)
            0: begin lo = 0; hi = 23; end
            1, 2: begin lo = 0; hi = 59; end
            3: begin lo = 1; hi = dim(m_f[4], m_f[5]); end
            4: begin lo = 1; hi = 12; end
            default: begin lo = 0; hi = 99; end
        endcase
        if (up) m_f[p] = (m_f[p] >= hi) ? lo : m_f[p] + 1;
        else    m_f[p] = (m_f[p] <= lo) ? hi : m_f[p] - 1;
    endtask

    task automatic model_step(input bit tk, input bit md, input bit nx, input bit up, input bit dn);
        if (!m_edit) begin
            if (tk) begin
                m_f[2]++;
                if (m_f[2] == 60) begin
                    m_f[2] = 0; m_f[1]++;
                    if (m_f[1] == 60) begin
                        m_f[1] = 0; m_f[0]++;
                        if (m_f[0] == 24) begin
                            m_f[0] = 0;
                            if (m_f[3] >= dim(m_f[4], m_f[5])) begin
                                m_f[3] = 1; m_f[4]++;
                                if (m_f[4] == 13) begin
                                    m_f[4] = 1; m_f[5] = (m_f[5] + 1) % 100;
                                end
                            end else m_f[3]++;
                        end
                    end
                end
            end
            if (md) begin m_edit = 1'b1; m_pos = 0; m_n = 0; end
        end else begin
            if (md) begin
                m_edit = 1'b0; m_pos = 0; m_n = 0;
                if (m_f[3] > dim(m_f[4], m_f[5])) m_f[3] = dim(m_f[4], m_f[5]);
            end else if (nx) begin
                m_pos = (m_pos + 1) % 6; m_n = 0;
            end else if (up || dn) begin
                model_adjust(m_pos, up); m_n = 0;
            end else m_n++;
        end
    endtask

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".alm"}, u_if.almacenamiento, exp_alm());
        chk({tag, ".pos"}, 48'(u_if.posicion), 48'(m_pos));
        chk({tag, ".cuadro"}, 48'(u_if.cuadro), 48'(m_edit));
        chk({tag, ".parpadeo"}, 48'(u_if.parpadeo), 48'(exp_blink()));
    endtask

    // Entered at posedge+1; leaves at the next posedge+1 with outputs checked.
    task automatic cyc(input string tag, input bit tk, input bit md, input bit nx,
                       input bit up, input bit dn);
        u_if.tick_1hz = tk; u_if.btn_mode = md; u_if.btn_next = nx;
        u_if.btn_up = up;   u_if.btn_down = dn;
        @(posedge dclk);
        model_step(tk, md, nx, up, dn);
        #1;
        u_if.tick_1hz = 1'b0; u_if.btn_mode = 1'b0; u_if.btn_next = 1'b0;
        u_if.btn_up = 1'b0;   u_if.btn_down = 1'b0;
        check_all(tag);
    endtask

    task automatic set_field(input int p, input int v);
        if (!m_edit) cyc("enter", 0, 1, 0, 0, 0);
        for (int k = 0; k < 8 && m_pos != p; k++) cyc("nav", 0, 0, 1, 0, 0);
        for (int k = 0; k < 110 && m_f[p] != v; k++) cyc("set", 0, 0, 0, 1, 0);
    endtask

    task automatic load(input int hh, input int mm, input int ss,
                        input int dd, input int mo, input int yy);
        set_field(5, yy); set_field(4, mo); set_field(3, dd);
        set_field(0, hh); set_field(1, mm); set_field(2, ss);
        cyc("leave", 0, 1, 0, 0, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        u_if.tick_1hz = 1'b0; u_if.btn_mode = 1'b0; u_if.btn_next = 1'b0;
        u_if.btn_up = 1'b0;   u_if.btn_down = 1'b0;
        clr_n = 1'b0;
        model_reset();
        #12;
        chk("rst.alm", u_if.almacenamiento, 48'h000000_010100);
        chk("rst.cuadro", 48'(u_if.cuadro), 48'h0);
        chk("rst.pos", 48'(u_if.posicion), 48'h0);
        chk("rst.parpadeo", 48'(u_if.parpadeo), 48'h1);
        @(negedge dclk) clr_n = 1'b1;
        @(posedge dclk); #1;

        // Run a few seconds.
        for (int i = 0; i < 3; i++) cyc("run", 1, 0, 0, 0, 0);
        chk("run.ss3", 48'(u_if.almacenamiento[31:24]), 48'h03);

        // Async reset in the middle of an edit discards it without a clock edge.
        cyc("enter", 0, 1, 0, 0, 0);
        cyc("edit_up", 0, 0, 0, 1, 0);
        #2 clr_n = 1'b0;
        #1;
        model_reset();
        chk("arst.alm", u_if.almacenamiento, 48'h000000_010100);
        chk("arst.cuadro", 48'(u_if.cuadro), 48'h0);
        chk("arst.pos", 48'(u_if.posicion), 48'h0);
        chk("arst.parpadeo", 48'(u_if.parpadeo), 48'h1);
        @(negedge dclk) clr_n = 1'b1;
        @(posedge dclk); #1;
        check_all("post_rst");

        // Calendar rollovers.
        load(23, 59, 59, 31, 12, 99); cyc("tick", 1, 0, 0, 0, 0);
        chk("roll.year", u_if.almacenamiento, 48'h000000_010100);
        load(23, 59, 59, 28, 2, 24); cyc("tick", 1, 0, 0, 0, 0);
        chk("roll.leap", u_if.almacenamiento, 48'h000000_290224);
        load(23, 59, 59, 28, 2, 23); cyc("tick", 1, 0, 0, 0, 0);
        chk("roll.feb", u_if.almacenamiento, 48'h000000_010323);
        load(23, 59, 59, 30, 4, 24); cyc("tick", 1, 0, 0, 0, 0);
        chk("roll.apr", u_if.almacenamiento, 48'h000000_010524);

        // Cursor movement and frozen time in EDIT.
        cyc("enter", 0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc("next", 0, 0, 1, 0, 0);
        chk("cur.pos5", 48'(u_if.posicion), 48'h5);
        cyc("next", 0, 0, 1, 0, 0);
        chk("cur.wrap", 48'(u_if.posicion), 48'h0);
        cyc("frozen", 1, 0, 0, 0, 0);
        cyc("frozen", 1, 0, 0, 0, 0);
        chk("frozen.ss", 48'(u_if.almacenamiento[31:24]), 48'h00);
        cyc("next", 0, 0, 1, 0, 0);
        cyc("mode_next", 0, 1, 1, 0, 0);
        chk("prio.cuadro", 48'(u_if.cuadro), 48'h0);
        chk("prio.pos", 48'(u_if.posicion), 48'h0);

        // Field wrap and BCD carry.
        set_field(0, 23);
        cyc("hh_up", 0, 0, 0, 1, 0);
        chk("hh.wrap_up", 48'(u_if.almacenamiento[47:40]), 48'h00);
        cyc("hh_dn", 0, 0, 0, 0, 1);
        chk("hh.wrap_dn", 48'(u_if.almacenamiento[47:40]), 48'h23);
        set_field(1, 9);
        cyc("mm_up", 0, 0, 0, 1, 0);
        chk("mm.bcd", 48'(u_if.almacenamiento[39:32]), 48'h10);
        set_field(5, 23); set_field(4, 2); set_field(3, 1);
        cyc("dd_dn", 0, 0, 0, 0, 1);
        chk("dd.wrap_dn", 48'(u_if.almacenamiento[23:16]), 48'h28);

        // Blink cadence and restart on a button.
        for (int i = 0; i < 3; i++) cyc("blink", 0, 0, 0, 0, 0);
        chk("blink.on3", 48'(u_if.parpadeo), 48'h1);
        cyc("blink", 0, 0, 0, 0, 0);
        chk("blink.off4", 48'(u_if.parpadeo), 48'h0);
        cyc("blink_up", 0, 0, 0, 1, 0);
        chk("blink.restart", 48'(u_if.parpadeo), 48'h1);
        for (int i = 0; i < 4; i++) cyc("blink", 0, 0, 0, 0, 0);
        chk("blink.off_again", 48'(u_if.parpadeo), 48'h0);
        for (int i = 0; i < 4; i++) cyc("blink", 0, 0, 0, 0, 0);
        chk("blink.on_again", 48'(u_if.parpadeo), 48'h1);

        // Day clamp on leaving EDIT.
        set_field(4, 1); set_field(3, 31); set_field(4, 2); set_field(5, 23);
        cyc("leave_clamp", 0, 1, 0, 0, 0);
        chk("clamp.dd", 48'(u_if.almacenamiento[23:16]), 48'h28);
        chk("clamp.cuadro", 48'(u_if.cuadro), 48'h0);

        // Random strobes against the model.
        for (int i = 0; i < 800; i++) begin
            cyc("rnd",
                $urandom_range(0, 2) == 0,
                $urandom_range(0, 19) == 0,
                $urandom_range(0, 4) == 0,
                $urandom_range(0, 2) == 0,
                $urandom_range(0, 2) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
